// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a host program into instruction memory and releases the core (optional XOR checksum: LOADER_CHECKSUM_EN)
module program_loader #(
    parameter int DEPTH     = 256,
    parameter int FLUSH_CYC = 3
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       START,
    input  logic                       host_VALID,
    output logic                       host_READY,
    input  logic [31:0]                host_DATA,
    input  logic                       host_LAST,
    output logic                       im_RESET,
    output logic                       im_WE,
    output logic [31:0]                im_DATA,
    output logic                       cpu_RESET,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       ERR,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic [31:0]                CHK
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEPTH);
    localparam logic [FW-1:0] FLUSH_END = FW'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        FLUSH,
        RUN
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [FW-1:0] flush_cnt;
    logic          accept;
    logic          start_load;

    assign accept     = host_VALID && host_READY;
    assign start_load = START && (state == IDLE || state == RUN);

    // state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= next_state;
    end

    // next-state and state-decoded outputs
    always_comb begin
        next_state = state;
        host_READY = 1'b0;
        im_RESET   = 1'b0;
        cpu_RESET  = 1'b1;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            IDLE: begin
                if (START) next_state = CLEAR;
            end
            CLEAR: begin
                im_RESET   = 1'b1;
                BUSY       = 1'b1;
                next_state = LOAD;
            end
            LOAD: begin
                host_READY = 1'b1;
                BUSY       = 1'b1;
                if (accept && (host_LAST || COUNT == CNT_LAST)) next_state = FLUSH;
            end
            FLUSH: begin
                BUSY = 1'b1;
                if (flush_cnt == FLUSH_END) next_state = RUN;
            end
            RUN: begin
                cpu_RESET = 1'b0;
                DONE      = 1'b1;
                if (START) next_state = CLEAR;
            end
            default: next_state = IDLE;
        endcase
    end

    // flush timer: idles at 0 outside FLUSH so it starts from 0 on every entry
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)             flush_cnt <= '0;
        else if (state != FLUSH)  flush_cnt <= '0;
        else                      flush_cnt <= flush_cnt + 1'b1;
    end

    // one-cycle write strobe per accepted word; data holds between writes
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            im_WE   <= 1'b0;
            im_DATA <= '0;
        end else begin
            im_WE <= accept;
            if (accept) im_DATA <= host_DATA;
        end
    end

    // word count and overflow flag, cleared when a new load begins
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            COUNT <= '0;
            ERR   <= 1'b0;
        end else if (start_load) begin
            COUNT <= '0;
            ERR   <= 1'b0;
        end else if (accept) begin
            if (COUNT != CNT_MAX) COUNT <= COUNT + 1'b1;
            if (COUNT == CNT_LAST && !host_LAST) ERR <= 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // running XOR of accepted words, updated alongside COUNT
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)        CHK <= '0;
        else if (start_load) CHK <= '0;
        else if (accept)     CHK <= CHK ^ host_DATA;
    end
`else
    assign CHK = '0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard testbench for program_loader
module tb_program_loader;

    localparam int DEPTH     = 4;
    localparam int FLUSH_CYC = 3;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic          CLK;
    logic          RESET_N;
    logic          START;
    logic          host_VALID;
    logic          host_READY;
    logic [31:0]   host_DATA;
    logic          host_LAST;
    logic          im_RESET;
    logic          im_WE;
    logic [31:0]   im_DATA;
    logic          cpu_RESET;
    logic          BUSY;
    logic          DONE;
    logic          ERR;
    logic [CW-1:0] COUNT;
    logic [31:0]   CHK;

    logic [31:0]   exp_q[$];
    logic [31:0]   exp_chk;
    int            tests;
    int            fails;

    program_loader #(.DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START),
        .host_VALID(host_VALID), .host_READY(host_READY),
        .host_DATA(host_DATA), .host_LAST(host_LAST),
        .im_RESET(im_RESET), .im_WE(im_WE), .im_DATA(im_DATA),
        .cpu_RESET(cpu_RESET), .BUSY(BUSY), .DONE(DONE),
        .ERR(ERR), .COUNT(COUNT), .CHK(CHK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_chk_val();
`ifdef LOADER_CHECKSUM_EN
        return exp_chk;
`else
        return 32'h0;
`endif
    endfunction

    always @(negedge CLK) begin : monitor
        logic [31:0] e;
        if (im_WE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("im_data", im_DATA, e);
            end
        end
    end

    task automatic start_load();
        @(negedge CLK);
        START      = 1'b1;
        host_VALID = 1'b0;
        @(negedge CLK);
        START   = 1'b0;
        exp_chk = 32'h0;
        check("clear_im_reset", {31'd0, im_RESET}, 32'd1);
        check("clear_busy", {31'd0, BUSY}, 32'd1);
        check("clear_cpu_reset", {31'd0, cpu_RESET}, 32'd1);
        check("clear_ready", {31'd0, host_READY}, 32'd0);
        check("clear_count", 32'(COUNT), 32'd0);
        check("clear_err", {31'd0, ERR}, 32'd0);
        check("clear_chk", CHK, 32'h0);
    endtask

    task automatic drive_word(input logic [31:0] d, input logic v, input logic l, input logic acc);
        @(negedge CLK);
        host_DATA  = d;
        host_VALID = v;
        host_LAST  = l;
        if (acc) begin
            exp_q.push_back(d);
            exp_chk = exp_chk ^ d;
        end
    endtask

    // extra=1 offers a word the loader must refuse and pulses START during FLUSH
    task automatic finish_load(input int exp_count, input logic exp_err, input logic extra);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            n = i;
            if (i == 1) begin
                check("flush_cpu_reset", {31'd0, cpu_RESET}, 32'd1);
                check("flush_ready", {31'd0, host_READY}, 32'd0);
                host_VALID = extra;
                host_LAST  = 1'b0;
                host_DATA  = 32'hDEADBEEF;
            end
            if (i == 2) begin
                host_VALID = 1'b0;
                START      = extra;
            end
            if (!cpu_RESET) begin
                START = 1'b0;
                break;
            end
        end
        check("flush_cycles", 32'(n - 1), 32'(FLUSH_CYC));
        check("run_done", {31'd0, DONE}, 32'd1);
        check("run_busy", {31'd0, BUSY}, 32'd0);
        check("run_count", 32'(COUNT), 32'(exp_count));
        check("run_err", {31'd0, ERR}, {31'd0, exp_err});
        check("run_chk", CHK, exp_chk_val());
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        @(negedge CLK);
        check("run_stays", {31'd0, DONE}, 32'd1);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        exp_chk    = 32'h0;
        RESET_N    = 1'b0;
        START      = 1'b0;
        host_VALID = 1'b0;
        host_DATA  = 32'h0;
        host_LAST  = 1'b0;

        // reset then idle
        repeat (2) @(negedge CLK);
        check("rst_cpu_reset", {31'd0, cpu_RESET}, 32'd1);
        check("rst_im_we", {31'd0, im_WE}, 32'd0);
        check("rst_im_data", im_DATA, 32'h0);
        check("rst_outputs", {26'd0, im_RESET, host_READY, BUSY, DONE, ERR, 1'b0}, 32'd0);
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_chk", CHK, 32'h0);
        RESET_N = 1'b1;
        repeat (5) @(negedge CLK);
        check("idle_cpu_reset", {31'd0, cpu_RESET}, 32'd1);
        check("idle_done", {31'd0, DONE}, 32'd0);
        check("idle_ready", {31'd0, host_READY}, 32'd0);

        // normal three-word load
        start_load();
        drive_word(32'h11111111, 1'b1, 1'b0, 1'b1);
        check("load_ready", {31'd0, host_READY}, 32'd1);
        drive_word(32'h22222222, 1'b1, 1'b0, 1'b1);
        drive_word(32'h44444444, 1'b1, 1'b1, 1'b1);
        finish_load(3, 1'b0, 1'b0);

        // reload from RUN with VALID gaps
        start_load();
        drive_word(32'hA5A5A5A5, 1'b1, 1'b0, 1'b1);
        drive_word(32'hBAD0BAD0, 1'b0, 1'b1, 1'b0);
        drive_word(32'hBAD1BAD1, 1'b0, 1'b0, 1'b0);
        drive_word(32'h0F0F0F0F, 1'b1, 1'b0, 1'b1);
        drive_word(32'h12345678, 1'b1, 1'b1, 1'b1);
        finish_load(3, 1'b0, 1'b0);

        // overflow: DEPTH words none flagged last, fifth word refused
        start_load();
        for (int k = 0; k < DEPTH; k++)
            drive_word(32'hC0DE0000 + 32'(k), 1'b1, 1'b0, 1'b1);
        finish_load(DEPTH, 1'b1, 1'b1);

        // reload clears ERR, then reset mid-load abandons it
        start_load();
        drive_word(32'h00000001, 1'b1, 1'b0, 1'b1);
        drive_word(32'h00000002, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        host_VALID = 1'b0;
        #2 RESET_N = 1'b0;
        #1;
        check("midrst_count", 32'(COUNT), 32'd0);
        check("midrst_cpu_reset", {31'd0, cpu_RESET}, 32'd1);
        check("midrst_busy", {31'd0, BUSY}, 32'd0);
        check("midrst_ready", {31'd0, host_READY}, 32'd0);
        check("midrst_sb_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        check("midrst_held", {31'd0, cpu_RESET}, 32'd1);
        start_load();
        drive_word(32'hFEEDF00D, 1'b1, 1'b1, 1'b1);
        finish_load(1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 256, giving the instruction-memory capacity in words.
REQ-002 The block SHALL have the parameter FLUSH_CYC, default 3, giving the cycles the core stays in reset after the last write.
REQ-003 One clock and one reset: port CLK (rising edge), port RESET_N (asynchronous assert, active-low).
REQ-004 Ports SHALL be, clock and reset first:
  CLK  in  1  system clock
  RESET_N  in  1  async active-low reset
  START  in  1  request a program load
  host_VALID  in  1  host word valid
  host_READY  out  1  loader accepts word
  host_DATA  in  32  instruction word
  host_LAST  in  1  marks final word
  im_RESET  out  1  clears instruction-memory write pointer
  im_WE  out  1  instruction-memory write strobe
  im_DATA  out  32  instruction-memory write data
  cpu_RESET  out  1  holds PC, register bank, flags, data memory and pipeline registers in reset
  BUSY  out  1  load in progress
  DONE  out  1  core released and running
  ERR  out  1  overflow on last load
  COUNT  out  $clog2(DEPTH)+1  words written by last load
  CHK  out  32  XOR checksum (see Configuration)

Function
REQ-005 The FSM SHALL have exactly the states IDLE, CLEAR, LOAD, FLUSH and RUN.
REQ-006 Transitions SHALL be:
  - IDLE->CLEAR on START.
  - CLEAR->LOAD unconditionally after 1 cycle.
  - LOAD->FLUSH on an accepted word with host_LAST, or on an accepted word at COUNT==DEPTH-1.
  - FLUSH->RUN after exactly FLUSH_CYC cycles.
  - RUN->CLEAR on START.
REQ-007 START SHALL be ignored in CLEAR, LOAD and FLUSH.
REQ-008 im_RESET SHALL be 1 only in CLEAR.
REQ-009 In CLEAR, COUNT, ERR and CHK SHALL be cleared to 0.
REQ-010 host_READY SHALL be 1 only in LOAD, combinationally from state.
REQ-011 A word is accepted on a cycle with host_VALID=1 and host_READY=1; host_DATA, host_LAST and host_VALID SHALL be ignored when host_READY=0.
REQ-012 An accepted word SHALL appear on im_DATA with im_WE=1 for exactly the following cycle.
REQ-013 Outside that cycle, im_WE SHALL be 0 and im_DATA SHALL hold its last value.
REQ-014 COUNT SHALL increment by 1 on the same edge that registers an accepted word.
REQ-015 COUNT SHALL saturate at DEPTH and never wrap.
REQ-016 Overflow: an accepted word at COUNT==DEPTH-1 with host_LAST=0 SHALL be written, ERR SHALL be set to 1, and the state SHALL go to FLUSH.
REQ-017 ERR SHALL hold until the next CLEAR.
REQ-018 cpu_RESET SHALL be 1 in every state except RUN.
REQ-019 cpu_RESET SHALL deassert on the FLUSH->RUN edge, after the final im_WE pulse.
REQ-020 BUSY SHALL be 1 in CLEAR, LOAD and FLUSH; DONE SHALL be 1 only in RUN.
REQ-021 START coincident with the FLUSH->RUN transition SHALL be ignored for that cycle.
REQ-022 The FLUSH cycle counter SHALL be $clog2(FLUSH_CYC+1) bits and SHALL reload to 0 on FLUSH entry.

Reset
REQ-023 RESET_N=0 SHALL force, asynchronously:
  - state=IDLE
  - cpu_RESET=1
  - im_RESET=0, im_WE=0, im_DATA=0
  - host_READY=0, BUSY=0, DONE=0, ERR=0
  - COUNT=0, CHK=0
REQ-024 Reset mid-LOAD or mid-FLUSH SHALL abandon the load; the core SHALL remain held in reset until a new load completes.
REQ-025 RESET_N SHALL be deasserted synchronously to CLK by the system; the block SHALL add no synchronizer.

Configuration
REQ-026 The macro LOADER_CHECKSUM_EN SHALL control the checksum feature.
REQ-027 With LOADER_CHECKSUM_EN defined, CHK SHALL be the bitwise XOR of all words accepted since CLEAR, updated on the same edge as COUNT.
REQ-028 Without LOADER_CHECKSUM_EN, CHK SHALL be tied to 0 and no checksum register SHALL be synthesized.

Verification
REQ-029 Reset then idle: RESET_N low 2 cycles, high, no START -> cpu_RESET=1, DONE=0, host_READY=0 indefinitely.
REQ-030 Normal load: START; words 0x11111111, 0x22222222, 0x44444444 (last flagged) with VALID held -> im_RESET pulse of 1 cycle, then 3 im_WE pulses carrying those values, COUNT=3, CHK=0x77777777 with macro, cpu_RESET falls 3 cycles after the last im_WE, DONE=1.
REQ-031 Backpressure gaps: VALID toggled 1,0,0,1,1(last) -> exactly 3 writes, no write on gap cycles.
REQ-032 Overflow with DEPTH=4: 5 words, none flagged last -> 4 writes, ERR=1, COUNT=4, fifth word not accepted (host_READY=0), enters RUN.
REQ-033 Reset mid-load: RESET_N low after 2 accepted words -> IDLE, COUNT=0, cpu_RESET=1; a subsequent START and 1-word load completes normally.
REQ-034 Reload from RUN: START in RUN -> cpu_RESET rises the next cycle, im_RESET pulses, ERR and CHK clear, new load proceeds.
